// File: rtl/spi_ctrl_pkg.sv
// Shared register offsets, CTRL/STATUS bit positions and engine state encoding
// for the memory-mapped SPI master.
package spi_ctrl_pkg;

  localparam logic [7:0] REG_CTRL       = 8'h00;
  localparam logic [7:0] REG_STATUS     = 8'h04;
  localparam logic [7:0] REG_TXDATA     = 8'h08;
  localparam logic [7:0] REG_RXDATA     = 8'h0C;
  localparam logic [7:0] REG_TXOCC      = 8'h10;
  localparam logic [7:0] REG_RXOCC      = 8'h14;
  localparam logic [7:0] REG_CTRL_ALIAS = 8'h60;

  localparam int unsigned CTRL_LOOP_BIT    = 0;
  localparam int unsigned CTRL_INHIBIT_BIT = 2;

  localparam int unsigned STAT_BUSY_BIT     = 0;
  localparam int unsigned STAT_RX_OVR_BIT   = 1;
  localparam int unsigned STAT_TX_FULL_BIT  = 2;
  localparam int unsigned STAT_RX_EMPTY_BIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_NEXT,
    ST_CS_HOLD
  } eng_state_e;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous FIFO with push/pop/full/empty/count; pushes while full and pops
// while empty are ignored. Read data is combinational from the head entry.
module spi_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr];
  assign count_o = count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Memory-mapped SPI mode-0 master with TX/RX byte FIFOs and a TX inhibit gate.
// Optional feature: define SPI_LOOPBACK_EN to make CTRL.LOOP route MOSI to the receiver.
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_hs_rd_i,
  input  logic        bus_hs_wr_i,
  input  logic [31:0] bus_hs_addr_i,
  input  logic [31:0] bus_hs_data_i,
  output logic        bus_hs_ready_o,
  output logic [31:0] bus_hs_data_o,
  output logic        spi_sclk_o,
  output logic        spi_cs_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned OW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]  reg_addr;
  logic        req_acc, is_wr, is_rd, ctrl_wr, stat_rd;
  logic        inhibit, loop_en, rx_ovr, busy;
  logic [31:0] rd_data;
  logic        unused_bits;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_dout;
  logic [OW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_dout;
  logic [OW-1:0] rx_count;

  eng_state_e    state, state_d;
  logic [DW-1:0] div_cnt;
  logic [3:0]    half_cnt;
  logic          div_end, can_go, miso_eff;
  logic          sclk, cs_n, mosi;
  logic [7:0]    tx_sh, rx_sh;

  assign unused_bits = ^{bus_hs_addr_i[31:8], bus_hs_data_i};

  assign reg_addr = bus_hs_addr_i[7:0];
  assign req_acc  = (bus_hs_rd_i || bus_hs_wr_i) && !bus_hs_ready_o;
  assign is_wr    = req_acc && bus_hs_wr_i;
  assign is_rd    = req_acc && !bus_hs_wr_i;
  assign ctrl_wr  = is_wr && (reg_addr == REG_CTRL || reg_addr == REG_CTRL_ALIAS);
  assign stat_rd  = is_rd && (reg_addr == REG_STATUS);
  assign tx_push  = is_wr && (reg_addr == REG_TXDATA);
  assign rx_pop   = is_rd && (reg_addr == REG_RXDATA);
  assign busy     = (state != ST_IDLE) || !cs_n;

  always_comb begin
    rd_data = '0;
    case (reg_addr)
      REG_CTRL: begin
        rd_data[CTRL_INHIBIT_BIT] = inhibit;
        rd_data[CTRL_LOOP_BIT]    = loop_en;
      end
      REG_STATUS: begin
        rd_data[STAT_BUSY_BIT]     = busy;
        rd_data[STAT_RX_OVR_BIT]   = rx_ovr;
        rd_data[STAT_TX_FULL_BIT]  = tx_full;
        rd_data[STAT_RX_EMPTY_BIT] = rx_empty;
      end
      REG_RXDATA: if (!rx_empty) rd_data[7:0] = rx_dout;
      REG_TXOCC:  rd_data = 32'(tx_count);
      REG_RXOCC:  rd_data = 32'(rx_count);
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus_hs_ready_o <= 1'b0;
      bus_hs_data_o  <= '0;
      inhibit        <= 1'b0;
      rx_ovr         <= 1'b0;
    end else begin
      bus_hs_ready_o <= req_acc;
      bus_hs_data_o  <= is_rd ? rd_data : '0;
      if (ctrl_wr) inhibit <= bus_hs_data_i[CTRL_INHIBIT_BIT];
      // an overflow in the same cycle as a STATUS read must not be lost
      if (rx_push && rx_full) rx_ovr <= 1'b1;
      else if (stat_rd)       rx_ovr <= 1'b0;
    end
  end

`ifdef SPI_LOOPBACK_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       loop_en <= 1'b0;
    else if (ctrl_wr) loop_en <= bus_hs_data_i[CTRL_LOOP_BIT];
  end
  assign miso_eff = loop_en ? mosi : spi_miso_i;
`else
  assign loop_en  = 1'b0;
  assign miso_eff = spi_miso_i;
`endif

  spi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_push),
    .data_i  (bus_hs_data_i[7:0]),
    .pop_i   (tx_pop),
    .data_o  (tx_dout),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  spi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_push),
    .data_i  (rx_sh),
    .pop_i   (rx_pop),
    .data_o  (rx_dout),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  assign div_end = (div_cnt == DW'(CLK_DIV - 1));
  assign can_go  = !inhibit && !tx_empty;

  // SHIFT covers the first 15 half-periods; NEXT is the 16th (SCLK high), so
  // the burst continues at NEXT's falling edge with no inter-byte gap.
  always_comb begin
    state_d = state;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    unique case (state)
      ST_IDLE: if (can_go) begin
        state_d = ST_CS_SETUP;
        tx_pop  = 1'b1;
      end
      ST_CS_SETUP: if (div_end) state_d = ST_SHIFT;
      ST_SHIFT:    if (div_end && half_cnt == 4'd14) state_d = ST_NEXT;
      ST_NEXT: begin
        rx_push = (div_cnt == '0);
        if (div_end) begin
          if (can_go) begin
            state_d = ST_SHIFT;
            tx_pop  = 1'b1;
          end else begin
            state_d = ST_CS_HOLD;
          end
        end
      end
      ST_CS_HOLD: if (div_end) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_cnt  <= '0;
      half_cnt <= '0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else begin
      if (state == ST_IDLE || div_end) div_cnt <= '0;
      else                             div_cnt <= div_cnt + 1'b1;

      if (state != ST_SHIFT)  half_cnt <= '0;
      else if (div_end)       half_cnt <= half_cnt + 1'b1;

      if ((state == ST_SHIFT || state == ST_NEXT) && div_end) sclk <= ~sclk;

      if (state == ST_SHIFT && div_end && !sclk) rx_sh <= {rx_sh[6:0], miso_eff};

      if (tx_pop) begin
        tx_sh <= tx_dout;
        mosi  <= tx_dout[7];
      end else if (state == ST_SHIFT && div_end && sclk) begin
        tx_sh <= {tx_sh[6:0], 1'b0};
        mosi  <= tx_sh[6];
      end

      if (state == ST_IDLE && tx_pop) begin
        cs_n <= 1'b0;
      end else if (state == ST_CS_HOLD && div_end) begin
        cs_n <= 1'b1;
        mosi <= 1'b0;
      end
    end
  end

  assign spi_sclk_o = sclk;
  assign spi_cs_n_o = cs_n;
  assign spi_mosi_o = mosi;

endmodule
